// File: rtl/tx_beam_pkg.sv
// Shared types and sizing helpers for the transmit delay scheduler.
package tx_beam_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Last counter value of a firing window; the window length is independent of the delays.
   function automatic int t_end(input int max_delay, input int pulse_cycles);
      return max_delay + pulse_cycles - 1;
   endfunction

   function automatic int cnt_width(input int max_delay, input int pulse_cycles);
      return idx_width(max_delay + pulse_cycles);
   endfunction

endpackage

// File: rtl/tx_delay_scheduler_if.sv
// Control/status bundle between the scan-sequence controller and the scheduler.
// tx_pulse_neg exists only when TX_BIPOLAR_EN is defined.
interface tx_delay_scheduler_if
   import tx_beam_pkg::*;
#(
   parameter int NUM_CH    = 8,
   parameter int MAX_DELAY = 256
);
   localparam int CH_W  = idx_width(NUM_CH);
   localparam int DLY_W = idx_width(MAX_DELAY);

   logic              cfg_valid;
   logic [CH_W-1:0]   cfg_ch;
   logic [DLY_W-1:0]  cfg_delay;
   logic              fire;
   logic              abort;
   logic              busy;
   logic              done;
   logic [NUM_CH-1:0] tx_pulse;
`ifdef TX_BIPOLAR_EN
   logic [NUM_CH-1:0] tx_pulse_neg;

   modport master (output cfg_valid, cfg_ch, cfg_delay, fire, abort,
                   input  busy, done, tx_pulse, tx_pulse_neg);
   modport slave  (input  cfg_valid, cfg_ch, cfg_delay, fire, abort,
                   output busy, done, tx_pulse, tx_pulse_neg);
`else
   modport master (output cfg_valid, cfg_ch, cfg_delay, fire, abort,
                   input  busy, done, tx_pulse);
   modport slave  (input  cfg_valid, cfg_ch, cfg_delay, fire, abort,
                   output busy, done, tx_pulse);
`endif

endinterface

// File: rtl/tx_channel_pulse.sv
// Per-channel window comparator with registered pulse output(s).
// With TX_BIPOLAR_EN the window splits into a positive half then a negative half.
module tx_channel_pulse #(
   parameter int T_W          = 9,
   parameter int DLY_W        = 8,
   parameter int PULSE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic [T_W-1:0]   t,
   input  logic [DLY_W-1:0] delay,
`ifdef TX_BIPOLAR_EN
   output logic             pulse_neg,
`endif
   output logic             pulse
);

   logic [T_W-1:0] start;
   logic [T_W-1:0] stop;

   // Counter width covers MAX_DELAY+PULSE_CYCLES, so the end bound never wraps.
   assign start = T_W'(delay);
   assign stop  = start + T_W'(PULSE_CYCLES);

`ifdef TX_BIPOLAR_EN
   logic [T_W-1:0] mid;
   assign mid = start + T_W'(PULSE_CYCLES / 2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pulse     <= 1'b0;
         pulse_neg <= 1'b0;
      end else begin
         pulse     <= run && (t >= start) && (t < mid);
         pulse_neg <= run && (t >= mid) && (t < stop);
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pulse <= 1'b0;
      else          pulse <= run && (t >= start) && (t < stop);
   end
`endif

endmodule

// File: rtl/tx_delay_scheduler.sv
// Transmit delay scheduler: shadow/active delay banks, IDLE/RUN FSM and firing counter.
// Optional TX_BIPOLAR_EN adds a negative-drive half pulse per channel.
module tx_delay_scheduler
   import tx_beam_pkg::*;
#(
   parameter int NUM_CH       = 8,
   parameter int MAX_DELAY    = 256,
   parameter int PULSE_CYCLES = 4
) (
   input logic                 clk,
   input logic                 reset_n,
   tx_delay_scheduler_if.slave bus
);

   localparam int DLY_W = idx_width(MAX_DELAY);
   localparam int T_W   = cnt_width(MAX_DELAY, PULSE_CYCLES);
   localparam int T_END = t_end(MAX_DELAY, PULSE_CYCLES);

   logic [DLY_W-1:0]  shadow [NUM_CH];
   logic [DLY_W-1:0]  active [NUM_CH];
   logic [T_W-1:0]    t;
   state_t            state, state_nx;
   logic              accept, finish, stop, run;
   logic [NUM_CH-1:0] pulse_vec;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      finish   = 1'b0;
      stop     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.fire) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            // abort wins over a coincident end of window, suppressing done
            if (bus.abort) begin
               stop     = 1'b1;
               state_nx = IDLE;
            end else if (t == T_W'(T_END)) begin
               stop     = 1'b1;
               finish   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         t        <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         state    <= state_nx;
         bus.busy <= (state_nx == RUN);
         bus.done <= finish;
         if (accept) begin
            active <= shadow;
            t      <= '0;
         end else if (state == RUN) begin
            t <= t + 1'b1;
         end
         if (bus.cfg_valid && (32'(bus.cfg_ch) < NUM_CH))
            shadow[bus.cfg_ch] <= bus.cfg_delay;
      end
   end

   assign run = (state == RUN) && !stop;

`ifdef TX_BIPOLAR_EN
   logic [NUM_CH-1:0] neg_vec;
   assign bus.tx_pulse_neg = neg_vec;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tx_channel_pulse #(
         .T_W          (T_W),
         .DLY_W        (DLY_W),
         .PULSE_CYCLES (PULSE_CYCLES)
      ) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .run       (run),
         .t         (t),
         .delay     (active[i]),
`ifdef TX_BIPOLAR_EN
         .pulse_neg (neg_vec[i]),
`endif
         .pulse     (pulse_vec[i])
      );
   end

   assign bus.tx_pulse = pulse_vec;

endmodule

// File: tb/tb_tx_delay_scheduler.sv
// Directed bench for tx_delay_scheduler with a firing-timeline reference model.
module tb_tx_delay_scheduler;

   localparam int NUM_CH       = 8;
   localparam int MAX_DELAY    = 256;
   localparam int PULSE_CYCLES = 4;
   localparam int WIN          = MAX_DELAY + PULSE_CYCLES;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   tx_delay_scheduler_if #(.NUM_CH(NUM_CH), .MAX_DELAY(MAX_DELAY)) bus ();

   tx_delay_scheduler #(
      .NUM_CH       (NUM_CH),
      .MAX_DELAY    (MAX_DELAY),
      .PULSE_CYCLES (PULSE_CYCLES)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: run_k = edges since fire acceptance (-1 when idle)
   int run_k = -1;
   bit done_m = 1'b0;
   int snap     [NUM_CH];
   int shadow_m [NUM_CH];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_k  = -1;
         done_m = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            snap[i]     = 0;
            shadow_m[i] = 0;
         end
      end else begin
         done_m = 1'b0;
         if (run_k < 0) begin
            if (bus.fire === 1'b1) begin
               snap  = shadow_m;
               run_k = 0;
            end
         end else if (bus.abort === 1'b1) begin
            run_k = -1;
         end else if (run_k == WIN - 1) begin
            run_k  = -1;
            done_m = 1'b1;
         end else begin
            run_k++;
         end
         if (bus.cfg_valid === 1'b1 && int'(bus.cfg_ch) < NUM_CH)
            shadow_m[bus.cfg_ch] = int'(bus.cfg_delay);
      end
   end

   // Every cycle: compare registered outputs against the model's timeline
   always @(negedge clk) begin
      logic [NUM_CH-1:0] ep, en;
      logic [NUM_CH-1:0] an;
      int r;
      ep = '0;
      en = '0;
      r  = run_k - 1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (run_k >= 1) begin
`ifdef TX_BIPOLAR_EN
            ep[i] = (r >= snap[i]) && (r < snap[i] + PULSE_CYCLES / 2);
            en[i] = (r >= snap[i] + PULSE_CYCLES / 2) && (r < snap[i] + PULSE_CYCLES);
`else
            ep[i] = (r >= snap[i]) && (r < snap[i] + PULSE_CYCLES);
`endif
         end
      end
`ifdef TX_BIPOLAR_EN
      an = bus.tx_pulse_neg;
`else
      an = '0;
`endif
      vectors++;
      if ({bus.busy, bus.done, bus.tx_pulse, an} !== {(run_k >= 0), done_m, ep, en}) begin
         miscompares++;
         $display("FAIL model t=%0t busy/done/pos/neg got %b/%b/%h/%h expected %b/%b/%h/%h",
                  $time, bus.busy, bus.done, bus.tx_pulse, an, (run_k >= 0), done_m, ep, en);
      end
   end

   int k = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic goto_k(input int target);
      while (k < target) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic load(input int ch, input int d);
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = 3'(ch);
      bus.cfg_delay = 8'(d);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
   endtask

   task automatic start_fire();
      bus.fire = 1'b1;
      @(negedge clk);
      bus.fire = 1'b0;
      k = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cfg_valid = 1'b0;
      bus.cfg_ch    = '0;
      bus.cfg_delay = '0;
      bus.fire      = 1'b0;
      bus.abort     = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_done", 32'(bus.done), 0);
      chk("reset_pulse", 32'(bus.tx_pulse), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Delays 0..7
      for (int i = 0; i < NUM_CH; i++) load(i, i);
      start_fire();
      chk("t1_busy_e0", 32'(bus.busy), 1);
      goto_k(1);  chk("t1_e1", 32'(bus.tx_pulse), 32'h01);
`ifdef TX_BIPOLAR_EN
      goto_k(4);  chk("t1_e4", 32'(bus.tx_pulse), 32'h0C);
      goto_k(5);  chk("t1_e5", 32'(bus.tx_pulse), 32'h18);
      goto_k(11); chk("t1_e11", 32'(bus.tx_pulse), 32'h00);
`else
      goto_k(4);  chk("t1_e4", 32'(bus.tx_pulse), 32'h0F);
      goto_k(5);  chk("t1_e5", 32'(bus.tx_pulse), 32'h1E);
      goto_k(11); chk("t1_e11", 32'(bus.tx_pulse), 32'h80);
`endif
      goto_k(12);  chk("t1_e12", 32'(bus.tx_pulse), 32'h00);
      goto_k(259); chk("t1_busy_e259", 32'(bus.busy), 1);
      goto_k(260); chk("t1_busy_e260", 32'(bus.busy), 0);
      chk("t1_done_e260", 32'(bus.done), 1);
      goto_k(261); chk("t1_done_e261", 32'(bus.done), 0);

      // Maximum delay on ch3
      load(3, 255);
      start_fire();
      goto_k(255); chk("t2_ch3_e255", 32'(bus.tx_pulse[3]), 0);
      goto_k(256); chk("t2_ch3_e256", 32'(bus.tx_pulse[3]), 1);
`ifdef TX_BIPOLAR_EN
      goto_k(259); chk("t2_ch3_e259", 32'(bus.tx_pulse[3]), 0);
`else
      goto_k(259); chk("t2_ch3_e259", 32'(bus.tx_pulse[3]), 1);
`endif
      goto_k(260); chk("t2_ch3_e260", 32'(bus.tx_pulse[3]), 0);
      chk("t2_done_e260", 32'(bus.done), 1);
      goto_k(261);

      // Write coinciding with fire: active keeps the old value
      load(0, 5);
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = 3'd0;
      bus.cfg_delay = 8'd10;
      start_fire();
      bus.cfg_valid = 1'b0;
      goto_k(5);   chk("t3_ch0_e5", 32'(bus.tx_pulse[0]), 0);
      goto_k(6);   chk("t3_ch0_e6", 32'(bus.tx_pulse[0]), 1);
      goto_k(261);
      start_fire();
      goto_k(10);  chk("t3_ch0_e10", 32'(bus.tx_pulse[0]), 0);
      goto_k(11);  chk("t3_ch0_e11", 32'(bus.tx_pulse[0]), 1);
      goto_k(261);

      // fire held: back-to-back firing accepted while done=1
      bus.fire = 1'b1;
      @(negedge clk);
      k = 0;
      goto_k(260); chk("t4_done_e260", 32'(bus.done), 1);
      chk("t4_busy_e260", 32'(bus.busy), 0);
      goto_k(261); chk("t4_busy_e261", 32'(bus.busy), 1);
      chk("t4_done_e261", 32'(bus.done), 0);
      bus.fire = 1'b0;
      goto_k(521); chk("t4_done_e521", 32'(bus.done), 1);
      goto_k(522); chk("t4_busy_e522", 32'(bus.busy), 0);

      // Abort mid-firing
      load(7, 100);
      start_fire();
      goto_k(50);  bus.abort = 1'b1;
      goto_k(51);  bus.abort = 1'b0;
      chk("t5_busy_e51", 32'(bus.busy), 0);
      chk("t5_done_e51", 32'(bus.done), 0);
      goto_k(52);  chk("t5_done_e52", 32'(bus.done), 0);
      goto_k(101); chk("t5_ch7_e101", 32'(bus.tx_pulse[7]), 0);
      bus.abort = 1'b1;
      goto_k(103); bus.abort = 1'b0;
      chk("t5_idle_abort_busy", 32'(bus.busy), 0);

      // Abort coinciding with end of window: no done
      start_fire();
      goto_k(259); bus.abort = 1'b1;
      goto_k(260); bus.abort = 1'b0;
      chk("t5_prio_done", 32'(bus.done), 0);
      chk("t5_prio_busy", 32'(bus.busy), 0);
      goto_k(261); chk("t5_prio_done_next", 32'(bus.done), 0);

      // Asynchronous reset mid-pulse
      start_fire();
      goto_k(3);   chk("t6_e3", 32'(bus.tx_pulse), 32'h06);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_async_pulse", 32'(bus.tx_pulse), 0);
      chk("t6_async_busy", 32'(bus.busy), 0);
      @(negedge clk);
      reset_n = 1'b1;
      start_fire();
      goto_k(2);   chk("t6_all_zero_e2", 32'(bus.tx_pulse), 32'hFF);
      goto_k(5);   chk("t6_all_zero_e5", 32'(bus.tx_pulse), 32'h00);
      goto_k(261);

`ifdef TX_BIPOLAR_EN
      load(2, 2);
      start_fire();
      goto_k(3); chk("bp_pos_e3", 32'(bus.tx_pulse[2]), 1);
      chk("bp_neg_e3", 32'(bus.tx_pulse_neg[2]), 0);
      goto_k(5); chk("bp_pos_e5", 32'(bus.tx_pulse[2]), 0);
      chk("bp_neg_e5", 32'(bus.tx_pulse_neg[2]), 1);
      goto_k(7); chk("bp_neg_e7", 32'(bus.tx_pulse_neg[2]), 0);
      goto_k(261);
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
